// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data-memory responder. Loads read the array
//               with one cycle of latency and forward from a one-entry store
//               buffer. Stores are posted into that buffer and drained into
//               the array on cycles that carry no load.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_byte_en,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_store_data,
  output logic                 rsp_valid,
  output logic [DataWidth-1:0] rsp_load_data,
  output logic                 rsp_err,
  output logic                 sbuf_valid
);

  localparam int c_lanes = DataWidth / 8;
  localparam int c_depth = 2 ** AddrWidth;

  // Byte-lane array; contents are deliberately not reset.
  logic [DataWidth-1:0] mem [c_depth];

  // Store buffer entry and response pipeline registers.
  logic                 sbuf_valid_q, sbuf_valid_d;
  logic [AddrWidth-1:0] sbuf_addr_q;
  logic [c_lanes-1:0]   sbuf_mask_q;
  logic [DataWidth-1:0] sbuf_data_q;
  logic [DataWidth-1:0] rd_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 ill_load_q;
  logic [c_lanes-1:0]   fwd_mask_q;
  logic [DataWidth-1:0] fwd_data_q;
  logic [DataWidth-1:0] hold_q;

  logic                 w_load;
  logic                 w_illegal;
  logic                 w_store;
  logic                 w_drain;
  logic                 w_hit;
  logic [c_lanes-1:0]   w_mask;
  logic [DataWidth-1:0] w_wdata;
  logic [DataWidth-1:0] w_merged;

  // Decode lane code into a byte mask and replicate store data across lanes.
  always_comb begin
    w_mask  = '0;
    w_wdata = req_store_data;
    case (req_byte_en)
      3'b000:  w_mask = 4'b0001;
      3'b001:  w_mask = 4'b0010;
      3'b010:  w_mask = 4'b0100;
      3'b011:  w_mask = 4'b1000;
      3'b100:  w_mask = 4'b0011;
      3'b101:  w_mask = 4'b1100;
      3'b110:  w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
    if (!req_byte_en[2]) begin
      w_wdata = {c_lanes{req_store_data[7:0]}};
    end else if (!req_byte_en[1]) begin
      w_wdata = {2{req_store_data[15:0]}};
    end
  end

  // A load owns the single array port; otherwise a pending entry drains.
  // Reset discards the buffer, so no drain is allowed during reset.
  assign w_load    = req_valid & ~req_we;
  assign w_illegal = req_valid & (req_byte_en == 3'b111);
  assign w_store   = req_valid & req_we & (w_mask != '0);
  assign w_drain   = sbuf_valid_q & ~w_load & ~brq_rst;
  assign w_hit     = sbuf_valid_q & (sbuf_addr_q == req_addr);

  // Next-state of the buffer flag: a new capture wins over a drain.
  always_comb begin
    sbuf_valid_d = sbuf_valid_q;
    if (w_store) begin
      sbuf_valid_d = 1'b1;
    end else if (w_drain) begin
      sbuf_valid_d = 1'b0;
    end
  end

  // Array port: byte-lane writes from the buffer, registered read for loads.
  always_ff @(posedge brq_clk) begin
    if (w_drain) begin
      for (int b = 0; b < c_lanes; b++) begin
        if (sbuf_mask_q[b]) begin
          mem[sbuf_addr_q][8*b +: 8] <= sbuf_data_q[8*b +: 8];
        end
      end
    end
    if (w_load) begin
      rd_q <= mem[req_addr];
    end
  end

  // Buffer payload and forwarding snapshot; validity is tracked separately.
  always_ff @(posedge brq_clk) begin
    if (w_store) begin
      sbuf_addr_q <= req_addr;
      sbuf_mask_q <= w_mask;
      sbuf_data_q <= w_wdata;
    end
    fwd_data_q <= sbuf_data_q;
  end

  // Control state with synchronous reset.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      sbuf_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      ill_load_q   <= 1'b0;
      fwd_mask_q   <= '0;
      hold_q       <= '0;
    end else begin
      sbuf_valid_q <= sbuf_valid_d;
      rsp_valid_q  <= w_load;
      rsp_err_q    <= w_illegal;
      ill_load_q   <= w_load & w_illegal;
      fwd_mask_q   <= (w_load && w_hit) ? sbuf_mask_q : '0;
      if (rsp_valid_q) begin
        hold_q <= w_merged;
      end
    end
  end

  // Merge forwarded lanes over array lanes; an illegal load returns zero.
  always_comb begin
    w_merged = '0;
    if (!ill_load_q) begin
      for (int b = 0; b < c_lanes; b++) begin
        w_merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : rd_q[8*b +: 8];
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign sbuf_valid    = sbuf_valid_q;
  assign rsp_load_data = rsp_valid_q ? w_merged : hold_q;

endmodule
`default_nettype wire
